// File: rtl/i2c_slave_target.sv
// I2C target with a single 7-bit address and a small byte register file.
// A pointer byte follows the write address; data bytes then stream into or
// out of the file with an auto-incrementing, wrapping pointer. SDA is
// open-drain (sda_oe_o pulls it low); SCL is never driven.
module i2c_slave_target #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50,
    parameter int         DEPTH      = 16,
    parameter int         PTR_W      = 4
) (
    input  logic             i2c_core_clock_i,
    input  logic             core_reset_i,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe_o,
    output logic             busy_o,
    output logic             wr_strobe_o,
    output logic [PTR_W-1:0] wr_addr_o,
    output logic [7:0]       wr_data_o,
    input  logic [PTR_W-1:0] reg_addr_i,
    output logic [7:0]       reg_rdata_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_PTR,
        S_PTR_ACK,
        S_WDATA,
        S_WDATA_ACK,
        S_RDATA,
        S_RDATA_ACK,
        S_WAIT_STOP
    } state_t;

    // Synchronizer stages: p0/p1 resynchronize, p2 holds the previous p1.
    logic scl_p0_q, scl_p1_q, scl_p2_q;
    logic sda_p0_q, sda_p1_q, sda_p2_q;

    state_t             state_q;
    logic               sda_oe_q;
    logic               busy_q;
    logic               wr_strobe_q;
    logic [PTR_W-1:0]   wr_addr_q;
    logic [7:0]         wr_data_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [2:0]         bit_cnt_q;
    logic [7:0]         shift_q;
    logic               rw_q;
    logic               ack_drv_q;
    logic [7:0]         mem_q [DEPTH];

    logic               scl_rise;
    logic               scl_fall;
    logic               start_det;
    logic               stop_det;
    logic               last_bit;
    logic [7:0]         byte_d;
    logic [PTR_W-1:0]   ptr_inc_d;
    logic [2:0]         bit_cnt_d;

    // Bring the asynchronous bus levels into the core clock domain.
    always_ff @(posedge i2c_core_clock_i) begin
        scl_p0_q <= scl_i;
        scl_p1_q <= scl_p0_q;
        scl_p2_q <= scl_p1_q;
        sda_p0_q <= sda_i;
        sda_p1_q <= sda_p0_q;
        sda_p2_q <= sda_p1_q;
    end

    // Bus events decoded from the synchronized levels. START/STOP require SCL
    // to be stable high across both samples so an SDA change that lands with
    // an SCL edge is never mistaken for a bus condition.
    assign scl_rise  =  scl_p1_q & ~scl_p2_q;
    assign scl_fall  = ~scl_p1_q &  scl_p2_q;
    assign start_det =  scl_p1_q &  scl_p2_q &  sda_p2_q & ~sda_p1_q;
    assign stop_det  =  scl_p1_q &  scl_p2_q & ~sda_p2_q &  sda_p1_q;
    assign last_bit  = (bit_cnt_q == 3'd7);
    assign byte_d    = {shift_q[6:0], sda_p1_q};
    assign ptr_inc_d = ptr_q + PTR_W'(1);
    assign bit_cnt_d = bit_cnt_q + 3'd1;

    // Protocol state machine, register file and all registered outputs.
    always_ff @(posedge i2c_core_clock_i) begin
        if (core_reset_i) begin
            state_q     <= S_IDLE;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            ptr_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            ack_drv_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_strobe_q <= 1'b0;
            if (start_det) begin
                state_q   <= S_ADDR;
                bit_cnt_q <= '0;
                sda_oe_q  <= 1'b0;
                busy_q    <= 1'b0;
                ack_drv_q <= 1'b0;
            end else if (stop_det) begin
                state_q   <= S_IDLE;
                sda_oe_q  <= 1'b0;
                busy_q    <= 1'b0;
                ack_drv_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        sda_oe_q <= 1'b0;
                    end

                    S_ADDR: begin
                        if (scl_rise) begin
                            shift_q   <= byte_d;
                            bit_cnt_q <= bit_cnt_d;
                            if (last_bit) begin
                                if (byte_d[7:1] == SLAVE_ADDR) begin
                                    rw_q      <= byte_d[0];
                                    busy_q    <= 1'b1;
                                    ack_drv_q <= 1'b0;
                                    state_q   <= S_ADDR_ACK;
                                end else begin
                                    state_q   <= S_WAIT_STOP;
                                end
                            end
                        end
                    end

                    // The first SCL fall after the 8th bit starts the ACK; the
                    // fall after the 9th pulse ends it and moves on.
                    S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                        if (scl_fall) begin
                            if (!ack_drv_q) begin
                                sda_oe_q  <= 1'b1;
                                ack_drv_q <= 1'b1;
                            end else begin
                                sda_oe_q  <= 1'b0;
                                ack_drv_q <= 1'b0;
                                bit_cnt_q <= '0;
                                if (state_q == S_ADDR_ACK) begin
                                    if (rw_q) begin
                                        shift_q  <= mem_q[ptr_q];
                                        sda_oe_q <= ~mem_q[ptr_q][7];
                                        state_q  <= S_RDATA;
                                    end else begin
                                        state_q  <= S_PTR;
                                    end
                                end else if (state_q == S_PTR_ACK) begin
                                    state_q <= S_WDATA;
                                end else begin
                                    ptr_q   <= ptr_inc_d;
                                    state_q <= S_WDATA;
                                end
                            end
                        end
                    end

                    S_PTR: begin
                        if (scl_rise) begin
                            shift_q   <= byte_d;
                            bit_cnt_q <= bit_cnt_d;
                            if (last_bit) begin
                                ptr_q     <= byte_d[PTR_W-1:0];
                                ack_drv_q <= 1'b0;
                                state_q   <= S_PTR_ACK;
                            end
                        end
                    end

                    S_WDATA: begin
                        if (scl_rise) begin
                            shift_q   <= byte_d;
                            bit_cnt_q <= bit_cnt_d;
                            if (last_bit) begin
                                mem_q[ptr_q] <= byte_d;
                                wr_strobe_q  <= 1'b1;
                                wr_addr_q    <= ptr_q;
                                wr_data_q    <= byte_d;
                                ack_drv_q    <= 1'b0;
                                state_q      <= S_WDATA_ACK;
                            end
                        end
                    end

                    // Bit 7 is already on the bus when this state is entered;
                    // each rise consumes a bit, each following fall presents the next.
                    S_RDATA: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[6:0], 1'b0};
                            bit_cnt_q <= bit_cnt_d;
                            if (last_bit) begin
                                state_q <= S_RDATA_ACK;
                            end
                        end else if (scl_fall) begin
                            sda_oe_q <= ~shift_q[7];
                        end
                    end

                    S_RDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe_q <= 1'b0;
                        end else if (scl_rise) begin
                            bit_cnt_q <= '0;
                            if (!sda_p1_q) begin
                                ptr_q   <= ptr_inc_d;
                                shift_q <= mem_q[ptr_inc_d];
                                state_q <= S_RDATA;
                            end else begin
                                sda_oe_q <= 1'b0;
                                state_q  <= S_WAIT_STOP;
                            end
                        end
                    end

                    S_WAIT_STOP: begin
                        sda_oe_q <= 1'b0;
                    end

                    default: begin
                        sda_oe_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign sda_oe_o    = sda_oe_q;
    assign busy_o      = busy_q;
    assign wr_strobe_o = wr_strobe_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign reg_rdata_o = mem_q[reg_addr_i];

endmodule
